// File: rtl/bus_write_tracer.sv
// bus_write_tracer
//   Watches a 6502-style CPU bus and records every write that lands inside
//   an address window into a small FIFO. Each entry holds the address, the
//   write data and a free-running timestamp taken in the cycle of the write.
//
// Ports
//   clk, reset       single clock, synchronous active-high reset
//   enable           capture enable; stored entries stay poppable when low
//   clear            flushes FIFO, overflow flag and drop counter
//   rw, clk2         CPU read/write strobe (0 = write) and phi2 clock
//   addr, odata      CPU address and write data buses
//   out_valid/ready  head-of-FIFO handshake
//   out_addr/data/ts head entry fields, all-zero while the FIFO is empty
//   count            number of entries held
//   overflow         sticky flag: a capture was dropped because the FIFO was full
//   drop_count       number of dropped captures, saturating at 8'hFF
module bus_write_tracer #(
  parameter int                ADDR_W = 16,
  parameter int                DATA_W = 8,
  parameter int                DEPTH  = 16,
  parameter int                TS_W   = 16,
  parameter logic [ADDR_W-1:0] WIN_LO = 16'h0000,
  parameter logic [ADDR_W-1:0] WIN_HI = 16'hFFFF,
  localparam int               CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic              rw,
  input  logic              clk2,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] odata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic [TS_W-1:0]   out_ts,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic [7:0]        drop_count
);

  localparam int                PTR_W    = CNT_W - 1;
  localparam int                ENTRY_W  = ADDR_W + DATA_W + TS_W;
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
  // Window test is done as (addr - WIN_LO) <= (WIN_HI - WIN_LO) with one
  // extra bit, so an address below WIN_LO wraps to a value above the span.
  localparam logic [ADDR_W:0]   SPAN     = {1'b0, WIN_HI - WIN_LO};

  logic [TS_W-1:0]    ts_q;
  logic               clk2_q;
  logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic [7:0]         dropCount_q, dropCount_d;
  logic [ENTRY_W-1:0] mem [DEPTH];

  logic [ADDR_W:0]    addrOffset;
  logic               inWindow;
  logic               phi2Rise;
  logic               captureEvt;
  logic               fifoFull;
  logic               popFire;
  logic               pushFire;
  logic               dropFire;
  logic               memWe;
  logic [ENTRY_W-1:0] headEntry;

  // Head-of-FIFO view; fields are forced to zero while nothing is held so
  // stale memory contents never leak out.
  always_comb begin
    headEntry  = mem[rdPtr_q];
    out_valid  = (count_q != '0);
    out_addr   = out_valid ? headEntry[ENTRY_W-1 -: ADDR_W] : '0;
    out_data   = out_valid ? headEntry[TS_W +: DATA_W] : '0;
    out_ts     = out_valid ? headEntry[TS_W-1:0] : '0;
    count      = count_q;
    overflow   = overflow_q;
    drop_count = dropCount_q;
  end

  // Capture detection and FIFO push/pop/drop decisions. A full FIFO still
  // accepts a capture when the head is popped in the same cycle.
  always_comb begin
    addrOffset = {1'b0, addr} - {1'b0, WIN_LO};
    inWindow   = (addrOffset <= SPAN);
    phi2Rise   = clk2 & ~clk2_q;
    captureEvt = phi2Rise & enable & ~rw & inWindow;
    fifoFull   = (count_q == FULL_CNT);
    popFire    = out_valid & out_ready;
    pushFire   = captureEvt & (~fifoFull | popFire);
    dropFire   = captureEvt & fifoFull & ~popFire;
  end

  // Next-state for pointers, occupancy and drop bookkeeping; clear wins
  // over any push or pop in the same cycle.
  always_comb begin
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    dropCount_d = dropCount_q;
    memWe       = 1'b0;
    if (clear) begin
      wrPtr_d     = '0;
      rdPtr_d     = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      dropCount_d = '0;
    end else begin
      memWe = pushFire;
      if (pushFire) begin
        wrPtr_d = wrPtr_q + PTR_W'(1);
      end
      if (popFire) begin
        rdPtr_d = rdPtr_q + PTR_W'(1);
      end
      if (pushFire && !popFire) begin
        count_d = count_q + CNT_W'(1);
      end else if (popFire && !pushFire) begin
        count_d = count_q - CNT_W'(1);
      end
      if (dropFire) begin
        overflow_d = 1'b1;
        if (dropCount_q != 8'hFF) begin
          dropCount_d = dropCount_q + 8'd1;
        end
      end
    end
  end

  // State registers. clk2_q resets high so a phi2 level that is already
  // high when reset releases is not mistaken for a rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ts_q        <= '0;
      clk2_q      <= 1'b1;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      dropCount_q <= '0;
    end else begin
      ts_q        <= ts_q + TS_W'(1);
      clk2_q      <= clk2;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      dropCount_q <= dropCount_d;
    end
  end

  // Trace storage; contents need no reset because the occupancy count
  // decides what is visible.
  always_ff @(posedge clk) begin
    if (!reset && memWe) begin
      mem[wrPtr_q] <= {addr, odata, ts_q};
    end
  end

endmodule

// File: doc/bus_write_tracer.md
BUS_WRITE_TRACER -- requirements
Module: bus_write_tracer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  ADDR_W  16  CPU address width
  DATA_W  8  CPU data width
  DEPTH  16  trace FIFO entries; power of two, >= 2
  TS_W  16  timestamp width
  WIN_LO  16'h0000  lowest captured address, inclusive
  WIN_HI  16'hFFFF  highest captured address, inclusive
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  single clock; all state updates on rising edge
  reset  in  1  synchronous, active-high reset
  enable  in  1  capture enable
  clear  in  1  synchronous flush of FIFO, overflow flag and drop counter
  rw  in  1  CPU read/write strobe; 0 = write
  clk2  in  1  CPU phi2 output
  addr  in  ADDR_W  CPU address bus
  odata  in  DATA_W  CPU write data bus
  out_valid  out  1  head entry available
  out_ready  in  1  consumer accepts head entry
  out_addr  out  ADDR_W  head entry address
  out_data  out  DATA_W  head entry data
  out_ts  out  TS_W  head entry timestamp
  count  out  clog2(DEPTH)+1  entries held
  overflow  out  1  sticky: a capture was dropped
  drop_count  out  8  dropped captures, saturating at 8'hFF
REQ-003 Clock and reset SHALL be one clock, clk, and a synchronous active-high reset, reset.

Function
REQ-004 A free-running timestamp counter SHALL increment by 1 every clk cycle, wrap from all-ones to 0, and not be affected by clear.
REQ-005 clk2 SHALL be registered as clk2_q each cycle; a phi2 rise SHALL be the cycle in which clk2==1 and clk2_q==0.
REQ-006 A capture event SHALL occur in a phi2-rise cycle when enable==1, rw==0, and WIN_LO <= addr <= WIN_HI (unsigned compare).
REQ-007 A capture SHALL record {addr, odata, timestamp} as sampled in the event cycle.
REQ-008 A pop SHALL occur in any cycle where out_valid==1 and out_ready==1.
REQ-009 out_valid SHALL equal (count != 0), and out_addr/out_data/out_ts SHALL show the oldest entry when out_valid==1 and all-zero when out_valid==0.
REQ-010 A captured entry SHALL become visible on the outputs in the cycle after the event (one-cycle latency) when the FIFO was empty.
REQ-011 Push without pop SHALL increment count; pop without push SHALL decrement count; push with pop SHALL leave count unchanged.
REQ-012 A push with count==DEPTH and a simultaneous pop SHALL be accepted, leaving count==DEPTH with no drop.
REQ-013 A push with count==DEPTH and no pop SHALL be discarded, set overflow to 1, and increment drop_count unless it already equals 8'hFF.
REQ-014 Entries SHALL leave the FIFO strictly in capture order; read and write pointers SHALL wrap modulo DEPTH.
REQ-015 clear SHALL take priority over push and pop in the same cycle: count, both pointers, overflow and drop_count go to 0 and that cycle's capture is discarded.
REQ-016 Deasserting enable SHALL stop new captures only; already-stored entries SHALL remain poppable.
REQ-017 out_valid SHALL NOT depend combinationally on out_ready.

Reset
REQ-018 While reset==1 at a clock edge, the block SHALL set timestamp=0, count=0, both pointers=0, overflow=0, drop_count=0, and clk2_q=1 (no spurious phi2 rise on the first post-reset cycle).
REQ-019 Reset SHALL take priority over clear, capture and pop, and SHALL discard all stored entries, including during an ongoing drain.
REQ-020 After reset, out_valid SHALL be 0 and out_addr/out_data/out_ts SHALL be 0.

Verification
REQ-021 Bench SHALL cover the following scenarios:
  a) reset, then phi2 rise with rw=0, addr=16'h0080, odata=8'h01 at timestamp 16'h003F -> next cycle out_valid=1, out_addr=16'h0080, out_data=8'h01, out_ts=16'h003F, count=1.
  b) writes to 16'h0080 (8'h01) then 16'h0081 (8'hFF), out_ready=1 -> popped in that order; count returns to 0; out_* return to 0.
  c) WIN_LO=16'h0100, WIN_HI=16'h01FF; writes to 16'h00FF, 16'h0100, 16'h01FF, 16'h0200 -> only 16'h0100 and 16'h01FF captured; rw=1 cycles never captured.
  d) DEPTH=4, out_ready=0, 6 captures -> count=4, overflow=1, drop_count=2; first 4 entries intact.
  e) FIFO full, capture and pop in the same cycle -> count stays 4, overflow stays 0.
  f) clear and a capture in the same cycle with 3 entries held -> count=0, overflow=0, drop_count=0, timestamp continues; reset asserted mid-drain -> all outputs at REQ-018/REQ-020 values next cycle.
